// File: rtl/zl_ts_pkg.sv
// Shared MPEG-TS constants, scheduler state encoding and the null-packet byte generator.
package zl_ts_pkg;

  localparam logic [7:0] TS_SYNC_BYTE   = 8'h47;
  localparam logic [7:0] TS_NULL_HDR1   = 8'h1F;
  localparam logic [7:0] TS_NULL_HDR2   = 8'hFF;
  localparam logic [7:0] TS_NULL_HDR3   = 8'h10;
  localparam logic [7:0] TS_STUFF_BYTE  = 8'hFF;
  localparam int unsigned TS_PKT_LEN    = 188;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    NULL = 2'd2
  } ts_state_e;

  // Header of a PID 0x1FFF packet followed by stuffing.
  function automatic logic [7:0] ts_null_byte(input int unsigned idx);
    case (idx)
      0:       return TS_SYNC_BYTE;
      1:       return TS_NULL_HDR1;
      2:       return TS_NULL_HDR2;
      3:       return TS_NULL_HDR3;
      default: return TS_STUFF_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/zl_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or after ptr, modulo N.
module zl_rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [PW-1:0] winner_idx,
  output logic          valid
);

  always_comb begin
    int unsigned idx;
    idx        = 0;
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!valid && eligible[idx]) begin
        valid       = 1'b1;
        winner[idx] = 1'b1;
        winner_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/zl_ts_mux.sv
// Packet-granular TS source scheduler feeding zl_dvb_s_core.
// Define ZL_TS_MUX_NULL_EN to emit null packets when no source is ready.
module zl_ts_mux
  import zl_ts_pkg::*;
#(
  parameter int unsigned N_SRC   = 2,
  parameter int unsigned PKT_LEN = TS_PKT_LEN,
  parameter int unsigned DROP_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*N_SRC-1:0]   src_data,
  input  logic [N_SRC-1:0]     src_req,
  output logic [N_SRC-1:0]     src_ack,
  output logic [7:0]           data_out,
  output logic                 data_out_req,
  input  logic                 data_out_ack,
  output logic [N_SRC-1:0]     grant,
  output logic [DROP_W-1:0]    drop_cnt,
  output logic                 null_active
);

  localparam int unsigned CW = $clog2(PKT_LEN);
  localparam int unsigned PW = $clog2(N_SRC);

  ts_state_e         state_q;
  logic [CW-1:0]     cnt_q;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     gidx_q;
  logic [N_SRC-1:0]  grant_q;
  logic [DROP_W-1:0] drop_q;

  logic [N_SRC-1:0]  is_sync;
  logic [N_SRC-1:0]  eligible;
  logic [N_SRC-1:0]  discard;
  logic [3:0]        n_discard;
  logic [DROP_W:0]   drop_sum;
  logic [DROP_W-1:0] drop_next;
  logic [N_SRC-1:0]  arb_winner;
  logic [PW-1:0]     arb_idx;
  logic              arb_valid;
  logic [7:0]        sel_byte;
  logic              sel_req;
  logic              last_byte;
  logic              xfer;

  always_comb begin
    is_sync   = '0;
    n_discard = '0;
    for (int k = 0; k < N_SRC; k++) begin
      is_sync[k] = (src_data[8*k +: 8] == TS_SYNC_BYTE);
    end
    eligible = src_req & is_sync;
    discard  = src_req & ~is_sync;
    for (int k = 0; k < N_SRC; k++) begin
      n_discard = n_discard + 4'(discard[k]);
    end
  end

  assign drop_sum  = {1'b0, drop_q} + (DROP_W+1)'(n_discard);
  assign drop_next = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];

  zl_rr_arbiter #(
    .N  (N_SRC),
    .PW (PW)
  ) u_arb (
    .eligible   (eligible),
    .ptr        (ptr_q),
    .winner     (arb_winner),
    .winner_idx (arb_idx),
    .valid      (arb_valid)
  );

  assign sel_byte  = src_data[8*gidx_q +: 8];
  assign sel_req   = src_req[gidx_q];
  assign last_byte = (cnt_q == CW'(PKT_LEN - 1));

  // Outputs are forced quiet for the whole cycle in which rst is high.
  always_comb begin
    src_ack      = '0;
    data_out     = 8'h00;
    data_out_req = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: src_ack = discard;
        PASS: begin
          data_out        = sel_byte;
          data_out_req    = sel_req;
          src_ack[gidx_q] = data_out_ack && sel_req;
        end
`ifdef ZL_TS_MUX_NULL_EN
        NULL: begin
          data_out     = ts_null_byte(32'(cnt_q));
          data_out_req = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign xfer     = data_out_req && data_out_ack;
  assign grant    = rst ? '0 : grant_q;
  assign drop_cnt = rst ? '0 : drop_q;

`ifdef ZL_TS_MUX_NULL_EN
  assign null_active = !rst && (state_q == NULL);
`else
  assign null_active = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      drop_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          drop_q <= drop_next;
          cnt_q  <= '0;
          if (arb_valid) begin
            grant_q <= arb_winner;
            gidx_q  <= arb_idx;
            ptr_q   <= (arb_idx == PW'(N_SRC - 1)) ? '0 : arb_idx + 1'b1;
            state_q <= PASS;
          end
`ifdef ZL_TS_MUX_NULL_EN
          else begin
            state_q <= NULL;
          end
`endif
        end
        PASS: begin
          if (xfer) begin
            if (last_byte) begin
              cnt_q   <= '0;
              grant_q <= '0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
`ifdef ZL_TS_MUX_NULL_EN
        NULL: begin
          if (xfer) begin
            if (last_byte) begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zl_ts_mux.sv
// Directed bench for zl_ts_mux: vector table for single-cycle behaviour, queued sources for packets.
module tb_zl_ts_mux;

  localparam int PL = 188;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] src_data;
  logic [1:0]  src_req;
  logic [1:0]  src_ack;
  logic [7:0]  data_out;
  logic        data_out_req;
  logic        data_out_ack;
  logic [1:0]  grant;
  logic [15:0] drop_cnt;
  logic        null_active;

  always #5 clk = ~clk;

  zl_ts_mux #(
    .N_SRC   (2),
    .PKT_LEN (PL),
    .DROP_W  (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .src_data     (src_data),
    .src_req      (src_req),
    .src_ack      (src_ack),
    .data_out     (data_out),
    .data_out_req (data_out_req),
    .data_out_ack (data_out_ack),
    .grant        (grant),
    .drop_cnt     (drop_cnt),
    .null_active  (null_active)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         hold0      = 1'b0;
  bit         ack_toggle = 1'b0;
  int         cyc        = 0;
  int         null_seen  = 0;

  logic [7:0] cap_byte[$];
  logic [1:0] cap_grant[$];
  int         cap_cyc[$];
  bit         cap_null[$];

  typedef struct {
    logic [1:0]  req;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        ack;
    logic [1:0]  e_ack;
    logic        e_req;
    logic [7:0]  e_dout;
    logic [1:0]  e_grant;
    logic [15:0] e_drop;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int k, input int p, input int i);
    if (i == 0) return 8'h47;
    return 8'(k * 97 + p * 31 + i);
  endfunction

  function automatic logic [7:0] null_exp(input int i);
    case (i)
      0:       return 8'h47;
      1:       return 8'h1F;
      2:       return 8'hFF;
      3:       return 8'h10;
      default: return 8'hFF;
    endcase
  endfunction

  // One clock: drive sources from the queues, sample just after, pop on handshake.
  task automatic cycle();
    @(negedge clk);
    src_req[0]     = (q0.size() > 0) && !hold0;
    src_data[7:0]  = src_req[0] ? q0[0] : 8'h00;
    src_req[1]     = (q1.size() > 0);
    src_data[15:8] = src_req[1] ? q1[0] : 8'h00;
    data_out_ack   = ack_toggle ? (cyc % 2 == 0) : 1'b1;
    #1;
    if (null_active) null_seen++;
    if (data_out_req && data_out_ack) begin
      cap_byte.push_back(data_out);
      cap_grant.push_back(grant);
      cap_cyc.push_back(cyc);
      cap_null.push_back(null_active);
    end
    if (src_req[0] && src_ack[0]) void'(q0.pop_front());
    if (src_req[1] && src_ack[1]) void'(q1.pop_front());
    cyc++;
  endtask

  task automatic clear_caps();
    cap_byte.delete();
    cap_grant.delete();
    cap_cyc.delete();
    cap_null.delete();
    null_seen = 0;
  endtask

  task automatic do_reset(input bit check_state);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    hold0      = 1'b0;
    ack_toggle = 1'b0;
    repeat (3) cycle();
    if (check_state) begin
      check("rst_grant", 32'(grant), 0);
      check("rst_req", 32'(data_out_req), 0);
      check("rst_dout", 32'(data_out), 0);
      check("rst_drop", 32'(drop_cnt), 0);
      check("rst_src_ack", 32'(src_ack), 0);
      check("rst_null", 32'(null_active), 0);
    end
    rst = 1'b0;
    clear_caps();
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int b;
    b = 0;
    while (cap_byte.size() < n && b < budget) begin
      cycle();
      b++;
    end
    check({name, "_count"}, 32'(cap_byte.size()), 32'(n));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    int   bad;
    int   gbad;
    rst          = 1'b1;
    src_req      = '0;
    src_data     = '0;
    data_out_ack = 1'b0;

    // ---- single-cycle vector table, starting right after reset ----
    tbl[0] = '{2'b11, 8'h33, 8'h47, 1'b0, 2'b01, 1'b0, 8'h00, 2'b00, 16'd0};
    tbl[1] = '{2'b11, 8'h47, 8'h47, 1'b1, 2'b10, 1'b1, 8'h47, 2'b10, 16'd1};
    tbl[2] = '{2'b11, 8'h12, 8'h9C, 1'b0, 2'b00, 1'b1, 8'h9C, 2'b10, 16'd1};
    tbl[3] = '{2'b01, 8'h12, 8'h77, 1'b1, 2'b00, 1'b0, 8'h77, 2'b10, 16'd1};
    tbl[4] = '{2'b10, 8'h00, 8'h5A, 1'b1, 2'b10, 1'b1, 8'h5A, 2'b10, 16'd1};

    do_reset(1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      src_req      = tbl[i].req;
      src_data     = {tbl[i].d1, tbl[i].d0};
      data_out_ack = tbl[i].ack;
      #1;
      check($sformatf("vec%0d_src_ack", i), 32'(src_ack), 32'(tbl[i].e_ack));
      check($sformatf("vec%0d_req", i), 32'(data_out_req), 32'(tbl[i].e_req));
      check($sformatf("vec%0d_dout", i), 32'(data_out), 32'(tbl[i].e_dout));
      check($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].e_grant));
      check($sformatf("vec%0d_drop", i), 32'(drop_cnt), 32'(tbl[i].e_drop));
    end

    // ---- src0 only, two back-to-back packets ----
    do_reset(1'b0);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < PL; i++) q0.push_back((i == 0) ? 8'h47 : 8'(i - 1));
    run_until(2 * PL, 500, "t1");
    bad = 0; gbad = 0;
    for (int j = 0; j < cap_byte.size(); j++) begin
      if (cap_byte[j] !== (((j % PL) == 0) ? 8'h47 : 8'((j % PL) - 1))) bad++;
      if (cap_grant[j] !== 2'b01) gbad++;
    end
    check("t1_bytes_bad", 32'(bad), 0);
    check("t1_grant_bad", 32'(gbad), 0);
    check("t1_bubble", (cap_cyc.size() > PL) ? 32'(cap_cyc[PL] - cap_cyc[PL-1]) : 32'hFFFF, 2);
    check("t1_drop", 32'(drop_cnt), 0);

    // ---- two sources always ready: strict alternation ----
    do_reset(1'b0);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < PL; i++) begin
        q0.push_back(pat(0, p, i));
        q1.push_back(pat(1, p, i));
      end
    run_until(4 * PL, 900, "t2");
    for (int j = 0; j < 4; j++) begin
      bad = 0; gbad = 0;
      for (int i = 0; i < PL; i++) begin
        if (cap_byte.size() > j * PL + i) begin
          if (cap_byte[j*PL+i] !== pat(j % 2, j / 2, i)) bad++;
          if (cap_grant[j*PL+i] !== 2'(1 << (j % 2))) gbad++;
        end
      end
      check($sformatf("t2_pkt%0d_bytes_bad", j), 32'(bad), 0);
      check($sformatf("t2_pkt%0d_grant_bad", j), 32'(gbad), 0);
    end

    // ---- ack toggling plus a 5-cycle source stall mid-packet ----
    do_reset(1'b0);
    for (int i = 0; i < PL; i++) q0.push_back(pat(0, 2, i));
    ack_toggle = 1'b1;
    begin
      bit held;
      int b;
      held = 1'b0;
      b    = 0;
      while (cap_byte.size() < PL && b < 600) begin
        if (!held && cap_byte.size() == 50) begin
          hold0 = 1'b1;
          cycle();
          check("t4_stall_req", 32'(data_out_req), 0);
          check("t4_stall_ack", 32'(src_ack), 0);
          repeat (4) cycle();
          hold0 = 1'b0;
          held  = 1'b1;
        end else begin
          cycle();
        end
        b++;
      end
    end
    repeat (10) cycle();
    check("t4_count", 32'(cap_byte.size()), PL);
    bad = 0; gbad = 0;
    for (int j = 0; j < cap_byte.size(); j++) begin
      if (cap_byte[j] !== pat(0, 2, j)) bad++;
      if (cap_grant[j] !== 2'b01) gbad++;
    end
    check("t4_bytes_bad", 32'(bad), 0);
    check("t4_grant_bad", 32'(gbad), 0);
    check("t4_grant_end", 32'(grant), 0);

`ifndef ZL_TS_MUX_NULL_EN
    // ---- out-of-sync bytes discarded before a packet on src1 ----
    do_reset(1'b0);
    q1.push_back(8'h12);
    q1.push_back(8'h34);
    q1.push_back(8'h56);
    for (int i = 0; i < PL; i++) q1.push_back(pat(1, 3, i));
    run_until(PL, 300, "t3");
    check("t3_drop", 32'(drop_cnt), 3);
    check("t3_first", (cap_byte.size() > 0) ? 32'(cap_byte[0]) : 32'hFFFF, 32'h47);
    bad = 0; gbad = 0;
    for (int j = 0; j < cap_byte.size(); j++) begin
      if (cap_byte[j] !== pat(1, 3, j)) bad++;
      if (cap_grant[j] !== 2'b10) gbad++;
    end
    check("t3_bytes_bad", 32'(bad), 0);
    check("t3_grant_bad", 32'(gbad), 0);

    // ---- reset mid-packet ----
    do_reset(1'b0);
    q0.push_back(8'h99);
    for (int i = 0; i < PL; i++) q0.push_back(pat(0, 4, i));
    run_until(100, 300, "t5_pre");
    check("t5_pre_drop", 32'(drop_cnt), 1);
    check("t5_pre_grant", 32'(grant), 32'h1);
    rst = 1'b1;
    cycle();
    cycle();
    check("t5_rst_req", 32'(data_out_req), 0);
    check("t5_rst_grant", 32'(grant), 0);
    check("t5_rst_drop", 32'(drop_cnt), 0);
    rst = 1'b0;
    q0.delete();
    q1.delete();
    clear_caps();
    for (int i = 0; i < PL; i++) begin
      q0.push_back(pat(0, 5, i));
      q1.push_back(pat(1, 5, i));
    end
    run_until(1, 10, "t5_post");
    check("t5_post_grant", (cap_grant.size() > 0) ? 32'(cap_grant[0]) : 32'hFFFF, 32'h1);
    check("t5_post_byte", (cap_byte.size() > 0) ? 32'(cap_byte[0]) : 32'hFFFF, 32'h47);

    // ---- no source: output stays idle ----
    do_reset(1'b0);
    repeat (20) cycle();
    check("idle_bytes", 32'(cap_byte.size()), 0);
    check("idle_null", 32'(null_seen), 0);
`else
    // ---- null packet, src0 arriving at null byte 50 ----
    do_reset(1'b0);
    begin
      bit added;
      int b;
      added = 1'b0;
      b     = 0;
      while (cap_byte.size() < 2 * PL && b < 600) begin
        if (!added && cap_byte.size() == 50) begin
          for (int i = 0; i < PL; i++) q0.push_back(pat(0, 6, i));
          added = 1'b1;
        end
        cycle();
        b++;
      end
    end
    check("tn_count", 32'(cap_byte.size()), 2 * PL);
    bad = 0; gbad = 0;
    for (int j = 0; j < cap_byte.size(); j++) begin
      if (j < PL) begin
        if (cap_byte[j] !== null_exp(j) || cap_null[j] !== 1'b1) bad++;
        if (cap_grant[j] !== 2'b00) gbad++;
      end else begin
        if (cap_byte[j] !== pat(0, 6, j - PL) || cap_null[j] !== 1'b0) bad++;
        if (cap_grant[j] !== 2'b01) gbad++;
      end
    end
    check("tn_bytes_bad", 32'(bad), 0);
    check("tn_grant_bad", 32'(gbad), 0);
    check("tn_bubble", (cap_cyc.size() > PL) ? 32'(cap_cyc[PL] - cap_cyc[PL-1]) : 32'hFFFF, 2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
